// File: rtl/matmul_lane_engine.sv
// matmul_lane_engine: sequential R = A x B over flat, row-major packed buses.
// LANES MAC lanes sweep the result columns in groups. Each group takes A_COLS
// cycles per result row.
// Configuration macro: MATMUL_SIGNED_EN. When it is defined, elements are
// two's complement. Otherwise all elements are unsigned.
module matmul_lane_engine #(
    parameter int A_ROWS = 5,
    parameter int A_COLS = 5,
    parameter int B_COLS = 5,
    parameter int ELEM_W = 8,
    parameter int ACC_W  = 19,
    parameter int LANES  = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [A_ROWS*A_COLS*ELEM_W-1:0]  a,
    input  logic [A_COLS*B_COLS*ELEM_W-1:0]  b,
    output logic [A_ROWS*B_COLS*ACC_W-1:0]   res,
    output logic                             busy,
    output logic                             done,
    output logic                             res_valid
);

    // Column groups per result row. The last group may be only partly filled.
    localparam int NGRP  = (B_COLS + LANES - 1) / LANES;
    // B is padded with zero columns so that every lane has a legal column index.
    localparam int NCOLP = NGRP * LANES;
    localparam int ROW_W = (A_ROWS > 1) ? $clog2(A_ROWS) : 1;
    localparam int K_W   = (A_COLS > 1) ? $clog2(A_COLS) : 1;
    localparam int GRP_W = (NGRP > 1)   ? $clog2(NGRP)   : 1;
    localparam int COL_W = (NCOLP > 1)  ? $clog2(NCOLP)  : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                          state_reg;
    logic [A_ROWS*A_COLS*ELEM_W-1:0] a_reg;
    logic [A_COLS*B_COLS*ELEM_W-1:0] b_reg;
    logic [ROW_W-1:0]                row_reg;
    logic [K_W-1:0]                  k_reg;
    logic [GRP_W-1:0]                colgroup_reg;
    logic [ACC_W-1:0]                acc_reg  [LANES];
    logic [ACC_W-1:0]                lane_sum [LANES];
    logic [ELEM_W-1:0]               a_elem   [A_ROWS][A_COLS];
    logic [ELEM_W-1:0]               b_elem   [A_COLS][NCOLP];
    logic                            accept;
    logic                            last_k;

    assign accept = (state_reg == IDLE) && start;
    assign last_k = (state_reg == MAC) && (k_reg == K_W'(A_COLS - 1));

    // Unpack the latched operands into element arrays. B is padded with zero columns.
    for (genvar gi = 0; gi < A_ROWS; gi++) begin : g_a_row
        for (genvar gj = 0; gj < A_COLS; gj++) begin : g_a_col
            assign a_elem[gi][gj] = a_reg[(A_ROWS*A_COLS-1-(gi*A_COLS+gj))*ELEM_W +: ELEM_W];
        end
    end

    for (genvar gi = 0; gi < A_COLS; gi++) begin : g_b_row
        for (genvar gj = 0; gj < NCOLP; gj++) begin : g_b_col
            if (gj < B_COLS) begin : g_real
                assign b_elem[gi][gj] = b_reg[(A_COLS*B_COLS-1-(gi*B_COLS+gj))*ELEM_W +: ELEM_W];
            end else begin : g_pad
                assign b_elem[gi][gj] = '0;
            end
        end
    end

    // Per-lane datapath: fetch the operands, form a full-width product and extend it to ACC_W.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [COL_W-1:0]  lane_col;
        logic [ELEM_W-1:0] a_op;
        logic [ELEM_W-1:0] b_op;
        logic [ACC_W-1:0]  prod_ext;

        assign lane_col = COL_W'(colgroup_reg) * COL_W'(LANES) + COL_W'(gi);
        assign a_op     = a_elem[row_reg][k_reg];
        assign b_op     = b_elem[k_reg][lane_col];
`ifdef MATMUL_SIGNED_EN
        logic signed [2*ELEM_W-1:0] prod;
        assign prod     = (2*ELEM_W)'($signed(a_op)) * (2*ELEM_W)'($signed(b_op));
        assign prod_ext = ACC_W'(prod);
`else
        logic [2*ELEM_W-1:0] prod;
        assign prod     = (2*ELEM_W)'(a_op) * (2*ELEM_W)'(b_op);
        assign prod_ext = ACC_W'(prod);
`endif
        assign lane_sum[gi] = acc_reg[gi] + prod_ext;
    end

    // Result storage, one column per block. Each column is written only by
    // its own lane, in its own group. Masked lanes therefore never write a column.
    for (genvar gi = 0; gi < B_COLS; gi++) begin : g_res_col
        localparam int               LANE = gi % LANES;
        localparam logic [GRP_W-1:0] GRP  = GRP_W'(gi / LANES);
        logic [ACC_W-1:0] col_reg [A_ROWS];

        // Clear on reset or on an accepted start. Capture the lane's final sum at the last k.
        always_ff @(posedge clk) begin
            if (rst || accept) begin
                for (int r = 0; r < A_ROWS; r++) begin
                    col_reg[r] <= '0;
                end
            end else if (last_k && (colgroup_reg == GRP)) begin
                col_reg[row_reg] <= lane_sum[LANE];
            end
        end

        for (genvar gj = 0; gj < A_ROWS; gj++) begin : g_res_row
            assign res[(A_ROWS*B_COLS-1-(gj*B_COLS+gi))*ACC_W +: ACC_W] = col_reg[gj];
        end
    end

    // Control FSM: counters, accumulators, operand latch and handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            res_valid    <= 1'b0;
            row_reg      <= '0;
            k_reg        <= '0;
            colgroup_reg <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            for (int l = 0; l < LANES; l++) begin
                acc_reg[l] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg        <= a;
                        b_reg        <= b;
                        res_valid    <= 1'b0;
                        row_reg      <= '0;
                        k_reg        <= '0;
                        colgroup_reg <= '0;
                        busy         <= 1'b1;
                        state_reg    <= MAC;
                        for (int l = 0; l < LANES; l++) begin
                            acc_reg[l] <= '0;
                        end
                    end
                end
                MAC: begin
                    if (k_reg == K_W'(A_COLS - 1)) begin
                        k_reg <= '0;
                        for (int l = 0; l < LANES; l++) begin
                            acc_reg[l] <= '0;
                        end
                        if (colgroup_reg == GRP_W'(NGRP - 1)) begin
                            colgroup_reg <= '0;
                            if (row_reg == ROW_W'(A_ROWS - 1)) begin
                                row_reg   <= '0;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                res_valid <= 1'b1;
                                state_reg <= DONE;
                            end else begin
                                row_reg <= row_reg + ROW_W'(1);
                            end
                        end else begin
                            colgroup_reg <= colgroup_reg + GRP_W'(1);
                        end
                    end else begin
                        k_reg <= k_reg + K_W'(1);
                        for (int l = 0; l < LANES; l++) begin
                            acc_reg[l] <= lane_sum[l];
                        end
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_lane_engine.sv
// Testbench for matmul_lane_engine. Three instances, with LANES = 1, 2 and 5,
// share the same stimulus. Each instance is checked against a plain-arithmetic
// reference model.
module tb_matmul_lane_engine;

    localparam int AR   = 5;
    localparam int AC   = 5;
    localparam int BC   = 5;
    localparam int EW   = 8;
    localparam int AW   = 19;
    localparam int AWID = AR*AC*EW;
    localparam int BWID = AC*BC*EW;
    localparam int RWID = AR*BC*AW;
    localparam int ND   = 3;

    logic            clk   = 1'b0;
    logic            rst   = 1'b1;
    logic            start = 1'b0;
    logic [AWID-1:0] a     = '0;
    logic [BWID-1:0] b     = '0;
    logic [RWID-1:0] res_o  [ND];
    logic            busy_o [ND];
    logic            done_o [ND];
    logic            rv_o   [ND];

    int errors = 0;
    int checks = 0;

    // Results of the most recent run_mult, per instance.
    int              lat_q    [ND];
    int              ndone_q  [ND];
    logic [RWID-1:0] snap_q   [ND];
    logic            rvdone_q [ND];
    logic            busybad_q[ND];

    always #5 clk = ~clk;

    matmul_lane_engine #(.A_ROWS(AR), .A_COLS(AC), .B_COLS(BC), .ELEM_W(EW), .ACC_W(AW), .LANES(1)) u_l1 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .res(res_o[0]), .busy(busy_o[0]), .done(done_o[0]), .res_valid(rv_o[0]));
    matmul_lane_engine #(.A_ROWS(AR), .A_COLS(AC), .B_COLS(BC), .ELEM_W(EW), .ACC_W(AW), .LANES(2)) u_l2 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .res(res_o[1]), .busy(busy_o[1]), .done(done_o[1]), .res_valid(rv_o[1]));
    matmul_lane_engine #(.A_ROWS(AR), .A_COLS(AC), .B_COLS(BC), .ELEM_W(EW), .ACC_W(AW), .LANES(5)) u_l5 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .res(res_o[2]), .busy(busy_o[2]), .done(done_o[2]), .res_valid(rv_o[2]));

    function automatic int lanes_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 2 : 5);
    endfunction

    // Latency is ceil(BC/L) groups per row, A_COLS cycles per group, plus the DONE cycle.
    function automatic int exp_lat(input int d);
        int l;
        l = lanes_of(d);
        return AR * ((BC + l - 1) / l) * AC + 1;
    endfunction

    function automatic logic [AWID-1:0] rand_vec();
        logic [AWID-1:0] v;
        v = '0;
        for (int i = 0; i < (AWID + 31) / 32; i++) begin
            v = (v << 32) | AWID'($urandom);
        end
        return v;
    endfunction

    // Kind 0: every row is [1..5]. Kind 1: identity. Kind 2: all 8'hFF.
    function automatic logic [AWID-1:0] make_mat(input int kind);
        logic [AWID-1:0] v;
        int e;
        v = '0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                e = (kind == 0) ? (j + 1) : ((kind == 1) ? ((i == j) ? 1 : 0) : 255);
                v = (v << EW) | AWID'(e);
            end
        end
        return v;
    endfunction

    function automatic logic [AW-1:0] get_elem(input logic [RWID-1:0] r, input int i, input int j);
        return AW'(r >> ((AR*BC-1-(i*BC+j))*AW));
    endfunction

    // Reference product: plain triple loop in 64-bit integers, reduced modulo 2^AW.
    function automatic logic [RWID-1:0] model(input logic [AWID-1:0] am, input logic [BWID-1:0] bm);
        logic [RWID-1:0] r;
        logic [EW-1:0]   ea;
        logic [EW-1:0]   eb;
        longint          s;
        longint          x;
        longint          y;
        r = '0;
        for (int i = 0; i < AR; i++) begin
            for (int j = 0; j < BC; j++) begin
                s = 0;
                for (int k = 0; k < AC; k++) begin
                    ea = EW'(am >> ((AR*AC-1-(i*AC+k))*EW));
                    eb = EW'(bm >> ((AC*BC-1-(k*BC+j))*EW));
`ifdef MATMUL_SIGNED_EN
                    x = longint'($signed(ea));
                    y = longint'($signed(eb));
`else
                    x = longint'(ea);
                    y = longint'(eb);
`endif
                    s = s + x * y;
                end
                r = r | (RWID'(AW'(s)) << ((AR*BC-1-(i*BC+j))*AW));
            end
        end
        return r;
    endfunction

    // Start one multiply and watch all instances for a fixed window.
    // The operand inputs are scrambled right after the start edge.
    // pulse_at > 1 pulses start again at that cycle count.
    task automatic run_mult(input logic [AWID-1:0] am, input logic [BWID-1:0] bm, input int pulse_at);
        @(negedge clk);
        a = am;
        b = bm;
        start = 1'b1;
        @(posedge clk);
        for (int d = 0; d < ND; d++) begin
            lat_q[d] = -1;
            ndone_q[d] = 0;
            snap_q[d] = '0;
            rvdone_q[d] = 1'b0;
            busybad_q[d] = 1'b0;
        end
        for (int cnt = 1; cnt <= 140; cnt++) begin
            @(negedge clk);
            if (cnt == 1) begin
                start = 1'b0;
                a = rand_vec();
                b = BWID'(rand_vec());
            end
            if (pulse_at > 1 && cnt == pulse_at) start = 1'b1;
            if (pulse_at > 1 && cnt == pulse_at + 1) start = 1'b0;
            for (int d = 0; d < ND; d++) begin
                if (done_o[d] === 1'b1) begin
                    ndone_q[d]++;
                    if (lat_q[d] < 0) begin
                        lat_q[d] = cnt;
                        snap_q[d] = res_o[d];
                        rvdone_q[d] = rv_o[d];
                        if (busy_o[d] !== 1'b0) busybad_q[d] = 1'b1;
                    end
                end else if (lat_q[d] < 0 && busy_o[d] !== 1'b1) begin
                    busybad_q[d] = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            checks++; if (busy_o[d] !== 1'b0) begin errors++; $display("FAIL reset_busy L%0d: got %b want 0", lanes_of(d), busy_o[d]); end
            checks++; if (done_o[d] !== 1'b0) begin errors++; $display("FAIL reset_done L%0d: got %b want 0", lanes_of(d), done_o[d]); end
            checks++; if (rv_o[d] !== 1'b0) begin errors++; $display("FAIL reset_res_valid L%0d: got %b want 0", lanes_of(d), rv_o[d]); end
            checks++; if (res_o[d] !== '0) begin errors++; $display("FAIL reset_res L%0d: got %h want 0", lanes_of(d), res_o[d]); end
        end
        rst = 1'b0;
        $display("reset: checked all instances");
    endtask

    task automatic test_row_pattern();
        logic [RWID-1:0] exp_r;
        run_mult(make_mat(0), BWID'(make_mat(0)), 0);
        exp_r = model(make_mat(0), BWID'(make_mat(0)));
        for (int d = 0; d < ND; d++) begin
            checks++; if (lat_q[d] !== exp_lat(d)) begin errors++; $display("FAIL row_latency L%0d: got %0d want %0d", lanes_of(d), lat_q[d], exp_lat(d)); end
            checks++; if (ndone_q[d] !== 1) begin errors++; $display("FAIL row_done_count L%0d: got %0d want 1", lanes_of(d), ndone_q[d]); end
            checks++; if (snap_q[d] !== exp_r) begin errors++; $display("FAIL row_result L%0d: got %h want %h", lanes_of(d), snap_q[d], exp_r); end
            checks++; if (rvdone_q[d] !== 1'b1 || busybad_q[d] !== 1'b0) begin errors++; $display("FAIL row_flags L%0d: res_valid %b busy_bad %b want 1 0", lanes_of(d), rvdone_q[d], busybad_q[d]); end
            for (int j = 0; j < BC; j++) begin
                checks++;
                if (get_elem(res_o[d], 3, j) !== AW'(15 * (j + 1))) begin
                    errors++; $display("FAIL row_elem L%0d (3,%0d): got %0d want %0d", lanes_of(d), j, get_elem(res_o[d], 3, j), 15 * (j + 1));
                end
            end
        end
        $display("row_pattern: latencies %0d %0d %0d", lat_q[0], lat_q[1], lat_q[2]);
    endtask

    task automatic test_identity();
        logic [BWID-1:0] bm;
        logic [RWID-1:0] exp_r;
        bm = BWID'(rand_vec());
        run_mult(make_mat(1), bm, 0);
        exp_r = '0;
        for (int i = 0; i < AR; i++) begin
            for (int j = 0; j < BC; j++) begin
                exp_r = exp_r | (RWID'(EW'(bm >> ((AC*BC-1-(i*BC+j))*EW))) << ((AR*BC-1-(i*BC+j))*AW));
            end
        end
        for (int d = 0; d < ND; d++) begin
            checks++; if (lat_q[d] !== exp_lat(d)) begin errors++; $display("FAIL ident_latency L%0d: got %0d want %0d", lanes_of(d), lat_q[d], exp_lat(d)); end
            checks++; if (snap_q[d] !== exp_r) begin errors++; $display("FAIL ident_result L%0d: got %h want %h", lanes_of(d), snap_q[d], exp_r); end
        end
        $display("identity: latencies %0d %0d %0d", lat_q[0], lat_q[1], lat_q[2]);
    endtask

    task automatic test_signedness();
        logic [AW-1:0] exp_e;
`ifdef MATMUL_SIGNED_EN
        exp_e = AW'(5);
`else
        exp_e = AW'(325125);
`endif
        run_mult(make_mat(2), BWID'(make_mat(2)), 0);
        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < AR; i++) begin
                checks++;
                if (get_elem(snap_q[d], i, (i + d) % BC) !== exp_e) begin
                    errors++; $display("FAIL sign_elem L%0d row %0d: got %0d want %0d", lanes_of(d), i, get_elem(snap_q[d], i, (i + d) % BC), exp_e);
                end
            end
        end
        $display("signedness: element value %0d", get_elem(snap_q[0], 0, 0));
    endtask

    task automatic test_random();
        logic [AWID-1:0] am;
        logic [BWID-1:0] bm;
        logic [RWID-1:0] exp_r;
        for (int t = 0; t < 3; t++) begin
            am = rand_vec();
            bm = BWID'(rand_vec());
            run_mult(am, bm, 0);
            exp_r = model(am, bm);
            for (int d = 0; d < ND; d++) begin
                checks++; if (snap_q[d] !== exp_r) begin errors++; $display("FAIL rand%0d_result L%0d: got %h want %h", t, lanes_of(d), snap_q[d], exp_r); end
                checks++; if (res_o[d] !== exp_r) begin errors++; $display("FAIL rand%0d_hold L%0d: got %h want %h", t, lanes_of(d), res_o[d], exp_r); end
                checks++; if (lat_q[d] !== exp_lat(d)) begin errors++; $display("FAIL rand%0d_latency L%0d: got %0d want %0d", t, lanes_of(d), lat_q[d], exp_lat(d)); end
            end
            $display("random %0d: latencies %0d %0d %0d", t, lat_q[0], lat_q[1], lat_q[2]);
        end
    endtask

    task automatic test_reset_mid();
        logic [AWID-1:0] am;
        logic [BWID-1:0] bm;
        int              late_done;
        @(negedge clk);
        a = make_mat(0);
        b = BWID'(make_mat(0));
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < ND; d++) begin
            checks++; if (busy_o[d] !== 1'b0) begin errors++; $display("FAIL midrst_busy L%0d: got %b want 0", lanes_of(d), busy_o[d]); end
            checks++; if (rv_o[d] !== 1'b0) begin errors++; $display("FAIL midrst_res_valid L%0d: got %b want 0", lanes_of(d), rv_o[d]); end
            checks++; if (res_o[d] !== '0) begin errors++; $display("FAIL midrst_res L%0d: got %h want 0", lanes_of(d), res_o[d]); end
        end
        late_done = 0;
        for (int c = 0; c < 130; c++) begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) if (done_o[d] !== 1'b0) late_done++;
        end
        checks++; if (late_done !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d done cycles want 0", late_done); end
        am = rand_vec();
        bm = BWID'(rand_vec());
        run_mult(am, bm, 0);
        for (int d = 0; d < ND; d++) begin
            checks++; if (snap_q[d] !== model(am, bm)) begin errors++; $display("FAIL midrst_after L%0d: got %h want %h", lanes_of(d), snap_q[d], model(am, bm)); end
        end
        $display("reset_mid: spurious done cycles %0d", late_done);
    endtask

    task automatic test_handshake();
        logic [AWID-1:0] am;
        logic [BWID-1:0] bm;
        int              waited;
        am = rand_vec();
        bm = BWID'(rand_vec());
        run_mult(am, bm, 10);
        for (int d = 0; d < ND; d++) begin
            checks++; if (ndone_q[d] !== 1) begin errors++; $display("FAIL busy_start_done_count L%0d: got %0d want 1", lanes_of(d), ndone_q[d]); end
            checks++; if (lat_q[d] !== exp_lat(d)) begin errors++; $display("FAIL busy_start_latency L%0d: got %0d want %0d", lanes_of(d), lat_q[d], exp_lat(d)); end
            checks++; if (snap_q[d] !== model(am, bm)) begin errors++; $display("FAIL busy_start_result L%0d: got %h want %h", lanes_of(d), snap_q[d], model(am, bm)); end
        end
        $display("handshake: done counts %0d %0d %0d", ndone_q[0], ndone_q[1], ndone_q[2]);
    endtask

    task automatic test_back_to_back();
        int waited;
        @(negedge clk);
        a = rand_vec();
        b = BWID'(rand_vec());
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (done_o[0] !== 1'b1 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        checks++; if (done_o[0] !== 1'b1) begin errors++; $display("FAIL b2b_done_timeout: got done %b want 1", done_o[0]); end
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy_o[0] !== 1'b1) begin errors++; $display("FAIL b2b_accept_busy: got %b want 1", busy_o[0]); end
        checks++; if (rv_o[0] !== 1'b0) begin errors++; $display("FAIL b2b_res_valid_clear: got %b want 0", rv_o[0]); end
        checks++; if (res_o[0] !== '0) begin errors++; $display("FAIL b2b_res_clear: got %h want 0", res_o[0]); end
        waited = 0;
        while ((busy_o[0] | busy_o[1] | busy_o[2] | done_o[0] | done_o[1] | done_o[2]) === 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        checks++; if (busy_o[0] !== 1'b0) begin errors++; $display("FAIL b2b_drain: got busy %b want 0", busy_o[0]); end
        $display("back_to_back: drained after %0d cycles", waited);
    endtask

    initial begin
        test_reset();
        test_row_pattern();
        test_identity();
        test_signedness();
        test_random();
        test_reset_mid();
        test_handshake();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
